game_sequencer: RTL

Parametrised top-level frame sequencer for the multi-player snake game. Each game tick it walks an erase → walls → fruits → snakes → move schedule, steps the pixel and segment counters that feed the datapath, and produces one-cycle move strobes. It also holds a registered, reverse-filtered heading for each of up to four players. The block sits between the keyboard decoders and the snake/fruit datapath and VGA plot mux. It adds a configurable player count and wall count, a pause mode and a clean restart path.

---
 rtl/game_sequencer_if.sv | 36 +++
 rtl/game_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// Sequencer <-> keyboard/datapath bundle. master = sequencer side,
// slave = the keyboard decoders plus the snake/fruit datapath and plot mux.
interface game_sequencer_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int XW          = 8,
  parameter int YW          = 7,
  parameter int SW          = 7
);
  logic                     start;
  logic                     pause;
  logic                     endgame;
  logic [NUM_PLAYERS-1:0]   dir_valid;
  logic [2*NUM_PLAYERS-1:0] dir_code;
  logic [2*NUM_PLAYERS-1:0] dir_out;
  logic                     plot;
  logic [2:0]               select;
  logic [XW-1:0]            counter_x;
  logic [YW-1:0]            counter_y;
  logic [2:0]               item_idx;
  logic [SW-1:0]            pixel_idx;
  logic                     move;
  logic                     move_fruit;
  logic                     busy;

  modport master (
    input  start, pause, endgame, dir_valid, dir_code,
    output dir_out, plot, select, counter_x, counter_y, item_idx, pixel_idx,
           move, move_fruit, busy
  );

  modport slave (
    output start, pause, endgame, dir_valid, dir_code,
    input  dir_out, plot, select, counter_x, counter_y, item_idx, pixel_idx,
           move, move_fruit, busy
  );
endinterface

// File: rtl/game_sequencer.sv
// Per-tick frame sequencer for the multi-player snake game: erase, walls,
// fruits, snakes, move; plus registered reverse-filtered player headings.
module game_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int NUM_WALLS   = 4,
  parameter int WALL_LEN    = 10,
  parameter int SNAKE_LEN   = 100,
  parameter int TICK_DIV    = 3333333,
  parameter int XW          = $clog2(SCREEN_W),
  parameter int YW          = $clog2(SCREEN_H),
  parameter int SW          = $clog2(SNAKE_LEN)
) (
  input logic              clock,
  input logic              resetn,
  game_sequencer_if.master bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [XW-1:0] X_LAST   = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(SCREEN_H - 1);
  localparam logic [SW-1:0] WALL_TOP = SW'(WALL_LEN - 1);
  localparam logic [SW-1:0] SNK_TOP  = SW'(SNAKE_LEN - 1);
  localparam logic [2:0]    W_LAST   = 3'(NUM_WALLS - 1);
  localparam logic [2:0]    P_LAST   = 3'(NUM_PLAYERS - 1);

  typedef enum logic [3:0] {
    IDLE, RESET_ERASE, ERASE, END_ERASE, WALL, FRUIT, MFRUIT, SNAKE,
    MOVE, WAIT, PAUSED
  } state_t;

  typedef struct packed {
    logic       plot;
    logic [2:0] sel;
    logic       mv;
    logic       busy;
  } out_t;

  function automatic out_t decode(input state_t s);
    out_t o;
    o      = '0;
    o.busy = !(s == IDLE || s == PAUSED);
    case (s)
      RESET_ERASE, ERASE, END_ERASE: begin o.plot = 1'b1; o.sel = 3'd1; end
      WALL:   begin o.plot = 1'b1; o.sel = 3'd3; end
      FRUIT:  begin o.plot = 1'b1; o.sel = 3'd2; end
      MFRUIT: begin o.plot = 1'b1; o.sel = 3'd4; end
      SNAKE:  begin o.plot = 1'b1; o.sel = 3'd5; end
      MOVE:   o.mv = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  logic [TW-1:0] tcnt;
  logic          tick;
  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!resetn || tick) tcnt <= '0;
    else                 tcnt <= tcnt + 1'b1;
  end

  state_t        state, nxt;
  logic [XW-1:0] cx, cx_n;
  logic [YW-1:0] cy, cy_n;
  logic [2:0]    item, item_n;
  logic [SW-1:0] pix, pix_n;
  out_t          outs, outs_n;

  always_comb begin
    nxt    = state;
    cx_n   = cx;
    cy_n   = cy;
    item_n = item;
    pix_n  = pix;
    if (bus.endgame && state != END_ERASE) begin
      nxt    = END_ERASE;
      cx_n   = '0;
      cy_n   = '0;
      item_n = '0;
      pix_n  = WALL_TOP;
    end else begin
      case (state)
        IDLE: if (bus.start) nxt = ERASE;
        RESET_ERASE, ERASE, END_ERASE: begin
          if (cx == X_LAST) begin
            cx_n = '0;
            if (cy == Y_LAST) begin
              cy_n = '0;
              nxt  = (state == ERASE) ? WALL : IDLE;
            end else begin
              cy_n = cy + 1'b1;
            end
          end else begin
            cx_n = cx + 1'b1;
          end
        end
        WALL: begin
          if (pix == '0) begin
            pix_n = WALL_TOP;
            if (item == W_LAST) begin
              item_n = '0;
              nxt    = FRUIT;
            end else begin
              item_n = item + 1'b1;
            end
          end else begin
            pix_n = pix - 1'b1;
          end
        end
        FRUIT: nxt = MFRUIT;
        MFRUIT: begin
          nxt    = SNAKE;
          item_n = '0;
          pix_n  = SNK_TOP;
        end
        SNAKE: begin
          if (pix == '0) begin
            if (item == P_LAST) begin
              // Leave the wall counter primed for the next frame.
              nxt    = MOVE;
              item_n = '0;
              pix_n  = WALL_TOP;
            end else begin
              item_n = item + 1'b1;
              pix_n  = SNK_TOP;
            end
          end else begin
            pix_n = pix - 1'b1;
          end
        end
        MOVE: nxt = WAIT;
        WAIT: begin
          if (bus.pause)  nxt = PAUSED;
          else if (tick)  nxt = ERASE;
        end
        PAUSED: if (!bus.pause) nxt = WAIT;
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state being entered so they line up with it.
  assign outs_n = decode(resetn ? nxt : RESET_ERASE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= RESET_ERASE;
      cx    <= '0;
      cy    <= '0;
      item  <= '0;
      pix   <= WALL_TOP;
    end else begin
      state <= nxt;
      cx    <= cx_n;
      cy    <= cy_n;
      item  <= item_n;
      pix   <= pix_n;
    end
    outs <= outs_n;
  end

  logic [2*NUM_PLAYERS-1:0] dir, pending;
  logic [NUM_PLAYERS-1:0]   pend_v;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      dir     <= {NUM_PLAYERS{2'b01}};
      pending <= '0;
      pend_v  <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        // Opposite headings sum to 3 (up/down, right/left).
        if (state == MOVE && pend_v[p] &&
            (3'(pending[2*p +: 2]) + 3'(dir[2*p +: 2]) != 3'd3))
          dir[2*p +: 2] <= pending[2*p +: 2];
        if (bus.dir_valid[p]) begin
          pending[2*p +: 2] <= bus.dir_code[2*p +: 2];
          pend_v[p]         <= 1'b1;
        end else if (state == MOVE) begin
          pend_v[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.dir_out    = dir;
  assign bus.plot       = outs.plot;
  assign bus.select     = outs.sel;
  assign bus.move       = outs.mv;
  assign bus.move_fruit = outs.mv;
  assign bus.busy       = outs.busy;
  assign bus.counter_x  = cx;
  assign bus.counter_y  = cy;
  assign bus.item_idx   = item;
  assign bus.pixel_idx  = pix;

endmodule
